// File: rtl/feature_pkg.sv
// rtl/feature_pkg.sv - shared sizes, feature stream order and reader FSM states
package feature_pkg;

  localparam int N_FEAT     = 17;
  localparam int DATA_W     = 32;
  localparam int FEAT_IDX_W = $clog2(N_FEAT);

  // Stream order of the feature words; value is the beat index on m_index.
  typedef enum logic [FEAT_IDX_W-1:0] {
    LPB_7    = 5'd0,
    LPB_14   = 5'd1,
    LPB_19   = 5'd2,
    LPB_25   = 5'd3,
    LPB_32   = 5'd4,
    LPB_38   = 5'd5,
    LPB_43   = 5'd6,
    LPB_125  = 5'd7,
    LPB_128  = 5'd8,
    LPB_132  = 5'd9,
    LPB_136  = 5'd10,
    LPB_137  = 5'd11,
    LPB_156  = 5'd12,
    LPB_161  = 5'd13,
    A_BIN198 = 5'd14,
    A_BIN199 = 5'd15,
    B_BIN208 = 5'd16
  } feat_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_STREAM
  } reader_state_t;

endpackage

// File: rtl/feature_capture_buffer.sv
// rtl/feature_capture_buffer.sv - snapshot register array with sync clear, parallel load, indexed read
module feature_capture_buffer
  import feature_pkg::*;
#(
  parameter int N     = N_FEAT,
  parameter int W     = DATA_W,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [N*W-1:0]   load_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [W-1:0]     rd_data
);

  logic [W-1:0] mem_q [N];
  logic [W-1:0] mem_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      mem_d[i] = mem_q[i];
      if (clear) begin
        mem_d[i] = '0;
      end else if (load) begin
        mem_d[i] = load_data[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Look-ahead reads one past the last word; those return zero.
  always_comb begin
    rd_data = '0;
    if (int'(rd_idx) < N) begin
      rd_data = mem_q[rd_idx];
    end
  end

endmodule

// File: rtl/feature_vector_reader.sv
// rtl/feature_vector_reader.sv - starts the extractor, waits with timeout, streams the captured vector
module feature_vector_reader
  import feature_pkg::*;
#(
  parameter int START_CYC   = 1,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                     clk_100,
  input  logic                     reset,
  input  logic                     run,
  output logic                     busy,
  output logic                     feature_start,
  input  logic                     done_features,
  input  logic [N_FEAT*DATA_W-1:0] feat_bus,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic [FEAT_IDX_W-1:0]    m_index,
  output logic                     m_last,
  output logic                     error_timeout
);

  localparam int START_W = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam int WAIT_W  = $clog2(TIMEOUT_CYC);
  localparam logic [START_W-1:0]    START_LAST = START_W'(START_CYC - 1);
  localparam logic [WAIT_W-1:0]     WAIT_LAST  = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [FEAT_IDX_W-1:0] IDX_LAST   = FEAT_IDX_W'(N_FEAT - 1);

  reader_state_t         state_q, state_d;
  logic [START_W-1:0]    start_cnt_q, start_cnt_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                  busy_q, busy_d;
  logic                  fstart_q, fstart_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_W-1:0]     m_data_q, m_data_d;
  logic [FEAT_IDX_W-1:0] m_index_q, m_index_d;
  logic                  m_last_q, m_last_d;
  logic                  err_q, err_d;
  logic                  buf_load;
  logic [FEAT_IDX_W-1:0] rd_idx;
  logic [DATA_W-1:0]     rd_data;

  assign rd_idx = m_index_q + FEAT_IDX_W'(1);

  feature_capture_buffer #(
    .N     (N_FEAT),
    .W     (DATA_W),
    .IDX_W (FEAT_IDX_W)
  ) u_buf (
    .clk       (clk_100),
    .clear     (reset),
    .load      (buf_load),
    .load_data (feat_bus),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    fstart_d    = fstart_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_index_d   = m_index_q;
    m_last_d    = m_last_q;
    err_d       = 1'b0;
    buf_load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d     = ST_START;
          start_cnt_d = '0;
          fstart_d    = 1'b1;
        end
      end
      ST_START: begin
        if (start_cnt_q == START_LAST) begin
          state_d    = ST_WAIT;
          fstart_d   = 1'b0;
          wait_cnt_d = '0;
        end else begin
          start_cnt_d = start_cnt_q + START_W'(1);
        end
      end
      ST_WAIT: begin
        // done is checked first so it wins over a coincident timeout
        if (done_features) begin
          buf_load  = 1'b1;
          state_d   = ST_STREAM;
          m_valid_d = 1'b1;
          m_index_d = '0;
          m_data_d  = feat_bus[DATA_W-1:0];
          m_last_d  = (IDX_LAST == '0);
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ST_STREAM: begin
        if (m_ready) begin
          if (m_last_q) begin
            state_d   = ST_IDLE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            m_index_d = '0;
            m_data_d  = '0;
          end else begin
            m_index_d = rd_idx;
            m_data_d  = rd_data;
            m_last_d  = (rd_idx == IDX_LAST);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      start_cnt_q <= '0;
      wait_cnt_q  <= '0;
      busy_q      <= 1'b0;
      fstart_q    <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_index_q   <= '0;
      m_last_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      busy_q      <= busy_d;
      fstart_q    <= fstart_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_index_q   <= m_index_d;
      m_last_q    <= m_last_d;
      err_q       <= err_d;
    end
  end

  assign busy          = busy_q;
  assign feature_start = fstart_q;
  assign m_valid       = m_valid_q;
  assign m_data        = m_data_q;
  assign m_index       = m_index_q;
  assign m_last        = m_last_q;
  assign error_timeout = err_q;

endmodule

// File: tb/tb_feature_vector_reader.sv
// tb/tb_feature_vector_reader.sv - directed self-checking bench for feature_vector_reader
module tb_feature_vector_reader;
  import feature_pkg::*;

  logic                     clk_100 = 1'b0;
  logic                     reset;
  logic                     run;
  logic                     busy;
  logic                     feature_start;
  logic                     done_features;
  logic [N_FEAT*DATA_W-1:0] feat_bus;
  logic                     m_valid;
  logic                     m_ready;
  logic [DATA_W-1:0]        m_data;
  logic [FEAT_IDX_W-1:0]    m_index;
  logic                     m_last;
  logic                     error_timeout;

  int checks = 0;
  int errors = 0;

  feature_vector_reader #(
    .START_CYC   (1),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk_100       (clk_100),
    .reset         (reset),
    .run           (run),
    .busy          (busy),
    .feature_start (feature_start),
    .done_features (done_features),
    .feat_bus      (feat_bus),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_index       (m_index),
    .m_last        (m_last),
    .error_timeout (error_timeout)
  );

  always #5 clk_100 = ~clk_100;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_pattern();
    for (int i = 0; i < N_FEAT; i++) begin
      feat_bus[i*DATA_W +: DATA_W] = 32'hA000_0000 + 32'(i);
    end
  endtask

  // Pulses run and checks the START cycle; returns at the first WAIT cycle.
  task automatic kick();
    @(negedge clk_100);
    run = 1'b1;
    done_features = 1'b0;
    @(negedge clk_100);
    run = 1'b0;
    chk("fs_high", feature_start, 1);
    chk("busy_start", busy, 1);
    @(negedge clk_100);
    chk("fs_low", feature_start, 0);
    chk("busy_wait", busy, 1);
  endtask

  task automatic wait_done(input int delay);
    repeat (delay - 1) @(negedge clk_100);
    chk("no_early_valid", m_valid, 0);
    done_features = 1'b1;
  endtask

  // mode 0 plain, 1 backpressure + stray run, 2 snapshot abuse, 3 reset at index 8
  task automatic stream_check(input int mode);
    int   exp_idx = 0;
    int   stall   = 0;
    int   cyc     = 0;
    logic tog     = 1'b1;
    logic rdy;
    while (exp_idx < N_FEAT && cyc < 300) begin
      @(negedge clk_100);
      cyc++;
      rdy = 1'b1;
      if (mode == 1 && exp_idx >= 3) begin
        if (stall < 5) begin
          rdy = 1'b0;
          stall++;
        end else begin
          rdy = tog;
          tog = ~tog;
        end
      end
      m_ready = rdy;
      run = (mode == 1 && exp_idx == 8);
      done_features = (mode == 2) ? cyc[0] : 1'b0;
      if (mode == 2) feat_bus = '1;
      chk("m_valid", m_valid, 1);
      chk("m_index", m_index, exp_idx);
      chk("m_data", m_data, 32'hA000_0000 + 32'(exp_idx));
      chk("m_last", m_last, exp_idx == N_FEAT - 1);
      chk("fs_quiet", feature_start, 0);
      if (mode == 3 && exp_idx == 8) begin
        reset = 1'b1;
        break;
      end
      if (rdy) exp_idx++;
    end
    run = 1'b0;
    done_features = 1'b0;
    if (mode != 3) begin
      chk("beat_count", exp_idx, N_FEAT);
      @(negedge clk_100);
      chk("end_valid", m_valid, 0);
      chk("end_busy", busy, 0);
      chk("end_last", m_last, 0);
      chk("end_index", m_index, 0);
      chk("end_fs", feature_start, 0);
      @(negedge clk_100);
      chk("idle_fs", feature_start, 0);
      chk("idle_busy", busy, 0);
    end
    m_ready = 1'b1;
  endtask

  initial begin
    int   n;
    logic saw_valid;

    reset = 1'b1;
    run = 1'b1;
    done_features = 1'b0;
    m_ready = 1'b1;
    feat_bus = '0;
    repeat (2) @(negedge clk_100);
    chk("rst_busy", busy, 0);
    chk("rst_fs", feature_start, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_index", m_index, 0);
    chk("rst_last", m_last, 0);
    chk("rst_err", error_timeout, 0);
    reset = 1'b0;
    run = 1'b0;
    @(negedge clk_100);
    chk("rst_run_ignored_fs", feature_start, 0);
    chk("rst_run_ignored_busy", busy, 0);

    load_pattern();
    kick();
    wait_done(50);
    stream_check(0);

    kick();
    wait_done(20);
    stream_check(1);

    kick();
    wait_done(5);
    stream_check(2);
    load_pattern();

    kick();
    n = 0;
    saw_valid = 1'b0;
    while (n < 150) begin
      @(negedge clk_100);
      n++;
      if (m_valid) saw_valid = 1'b1;
      if (error_timeout) break;
    end
    chk("timeout_cycles", n, 100);
    chk("timeout_pulse", error_timeout, 1);
    chk("timeout_busy", busy, 0);
    @(negedge clk_100);
    chk("timeout_once", error_timeout, 0);
    chk("timeout_no_valid", saw_valid, 0);

    kick();
    wait_done(30);
    stream_check(0);

    kick();
    wait_done(10);
    stream_check(3);
    @(negedge clk_100);
    reset = 1'b0;
    chk("midrst_valid", m_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_index", m_index, 0);
    chk("midrst_data", m_data, 0);

    kick();
    wait_done(12);
    stream_check(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
